// File: rtl/std_axi_mem_responder_pkg.sv
// Shared types for the dcache AXI memory responder: AXI widths, channel structs,
// burst/resp encodings and the responder FSM state enum.
package std_axi_mem_responder_pkg;

  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiIdWidth   = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } axi_mem_state_e;

  typedef struct packed {
    logic                      aw_valid;
    logic [AxiIdWidth-1:0]     aw_id;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [5:0]                aw_atop;
    logic                      w_valid;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;
    logic                      b_ready;
    logic                      ar_valid;
    logic [AxiIdWidth-1:0]     ar_id;
    logic [AxiAddrWidth-1:0]   ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic                      r_ready;
  } std_axi_req_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic                    ar_ready;
    logic                    b_valid;
    logic [AxiIdWidth-1:0]   b_id;
    logic [1:0]              b_resp;
    logic                    r_valid;
    logic [AxiIdWidth-1:0]   r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
  } std_axi_rsp_t;

endpackage

// File: rtl/std_axi_burst_addr.sv
// Combinational AXI next-beat address for FIXED/INCR/WRAP bursts; shared by
// the read and write paths of the memory responder.
module std_axi_burst_addr
  import std_axi_mem_responder_pkg::*;
(
  input  logic [AxiAddrWidth-1:0] addr,
  input  logic [7:0]              len,
  input  logic [2:0]              size,
  input  logic [1:0]              burst,
  output logic [AxiAddrWidth-1:0] next_addr
);

  logic [AxiAddrWidth-1:0] incr;
  logic [AxiAddrWidth-1:0] cont;
  logic [AxiAddrWidth-1:0] base;
  logic [AxiAddrWidth-1:0] sum;

  always_comb begin
    incr = AxiAddrWidth'(1) << size;
    cont = (AxiAddrWidth'(len) + AxiAddrWidth'(1)) << size;
    base = addr & ~(cont - AxiAddrWidth'(1));
    sum  = addr + incr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      // reaching the top of the aligned container folds back to its base
      BURST_WRAP:  next_addr = (sum == base + cont) ? base : sum;
      default:     next_addr = sum;
    endcase
  end

endmodule

// File: rtl/std_axi_mem_responder.sv
// AXI4 responder backed by a word-wide single-port SRAM, one transaction at a time.
// Optional macro CVA6_AXI_MEM_RESP_ERR_EN: SLVERR on out-of-range beats and illegal WRAP lengths.
module std_axi_mem_responder
  import std_axi_mem_responder_pkg::*;
#(
  parameter int unsigned NumWords = 1024,
  parameter type axi_req_t = std_axi_req_t,
  parameter type axi_rsp_t = std_axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output logic     busy_o
);

  localparam int unsigned OFF_W = $clog2(AxiDataWidth / 8);
  localparam int unsigned IDX_W = $clog2(NumWords);

  axi_mem_state_e            state;
  logic [AxiIdWidth-1:0]     id_q;
  logic [AxiAddrWidth-1:0]   addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      last_wr_q;
  logic                      err_q;
  logic [AxiAddrWidth-1:0]   next_addr;
  logic [IDX_W-1:0]          idx;
  logic                      beat_err;
  logic                      ar_rdy, aw_rdy, ar_hs, aw_hs, mem_we;
  logic                      r_valid, r_last, b_valid;
  logic [AxiDataWidth-1:0]   r_data;
  logic [AxiIdWidth-1:0]     r_id, b_id;
  logic [1:0]                r_resp, b_resp;
  logic [AxiDataWidth-1:0]   mem [NumWords];
  logic                      unused_ok;

  assign unused_ok = ^{axi_req_i.aw_lock, axi_req_i.aw_atop, axi_req_i.ar_lock, axi_req_i.w_last};

  std_axi_burst_addr u_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign idx = addr_q[IDX_W+OFF_W-1:OFF_W];

`ifdef CVA6_AXI_MEM_RESP_ERR_EN
  logic wrap_bad_q;

  function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_WRAP) &&
           !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
  endfunction

  always_ff @(posedge clk_i) begin
    if (ar_hs)
      wrap_bad_q <= wrap_bad(axi_req_i.ar_burst, axi_req_i.ar_len);
    else if (aw_hs)
      wrap_bad_q <= wrap_bad(axi_req_i.aw_burst, axi_req_i.aw_len);
  end

  assign beat_err = (|addr_q[AxiAddrWidth-1:IDX_W+OFF_W]) || wrap_bad_q;
`else
  assign beat_err = 1'b0;
`endif

  // Collisions go to the opposite of the last serviced direction; reads win after reset.
  assign ar_rdy = (state == IDLE) && !rst_i && (!axi_req_i.aw_valid || last_wr_q);
  assign aw_rdy = (state == IDLE) && !rst_i && (!axi_req_i.ar_valid || !last_wr_q);
  assign ar_hs  = ar_rdy && axi_req_i.ar_valid;
  assign aw_hs  = aw_rdy && axi_req_i.aw_valid && !ar_hs;
  assign mem_we = (state == WR_DATA) && axi_req_i.w_valid && !beat_err && !rst_i;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < AxiDataWidth / 8; b++) begin
        if (axi_req_i.w_strb[b]) mem[idx][8*b +: 8] <= axi_req_i.w_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last_wr_q <= 1'b1;
      err_q     <= 1'b0;
      beat_q    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      b_valid   <= 1'b0;
      r_data    <= '0;
      r_id      <= '0;
      b_id      <= '0;
      r_resp    <= RESP_OKAY;
      b_resp    <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            id_q      <= axi_req_i.ar_id;
            addr_q    <= axi_req_i.ar_addr;
            len_q     <= axi_req_i.ar_len;
            size_q    <= axi_req_i.ar_size;
            burst_q   <= axi_req_i.ar_burst;
            beat_q    <= '0;
            last_wr_q <= 1'b0;
            state     <= RD_REQ;
          end else if (aw_hs) begin
            id_q      <= axi_req_i.aw_id;
            addr_q    <= axi_req_i.aw_addr;
            len_q     <= axi_req_i.aw_len;
            size_q    <= axi_req_i.aw_size;
            burst_q   <= axi_req_i.aw_burst;
            beat_q    <= '0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b1;
            state     <= WR_DATA;
          end
        end
        RD_REQ: begin
          r_data  <= beat_err ? '0 : mem[idx];
          r_resp  <= beat_err ? RESP_SLVERR : RESP_OKAY;
          r_id    <= id_q;
          r_last  <= (beat_q == len_q);
          r_valid <= 1'b1;
          addr_q  <= next_addr;
          state   <= RD_DATA;
        end
        RD_DATA: begin
          // the next word is fetched on the same edge that retires the current beat
          if (axi_req_i.r_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              state   <= IDLE;
            end else begin
              beat_q <= beat_q + 8'd1;
              r_data <= beat_err ? '0 : mem[idx];
              r_resp <= beat_err ? RESP_SLVERR : RESP_OKAY;
              r_last <= (beat_q + 8'd1 == len_q);
              addr_q <= next_addr;
            end
          end
        end
        WR_DATA: begin
          if (axi_req_i.w_valid) begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr;
            err_q  <= err_q | beat_err;
            if (beat_q == len_q) begin
              b_valid <= 1'b1;
              b_id    <= id_q;
              b_resp  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
              state   <= WR_RESP;
            end
          end
        end
        WR_RESP: begin
          if (axi_req_i.b_ready) begin
            b_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.ar_ready = ar_rdy;
    axi_rsp_o.aw_ready = aw_rdy;
    axi_rsp_o.w_ready  = (state == WR_DATA);
    axi_rsp_o.b_valid  = b_valid;
    axi_rsp_o.b_id     = b_id;
    axi_rsp_o.b_resp   = b_resp;
    axi_rsp_o.r_valid  = r_valid;
    axi_rsp_o.r_id     = r_id;
    axi_rsp_o.r_data   = r_data;
    axi_rsp_o.r_resp   = r_resp;
    axi_rsp_o.r_last   = r_last;
  end

endmodule

// File: tb/tb_std_axi_mem_responder.sv
// Scoreboard bench for std_axi_mem_responder: directed bursts push expected R/B
// responses; a negedge monitor pops and compares them on each handshake.
module tb_std_axi_mem_responder;
  import std_axi_mem_responder_pkg::*;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  localparam logic [63:0] P0 = 64'h0000_0040_DEAD_0040;
  localparam logic [63:0] P1 = 64'h0000_0041_DEAD_0041;
  localparam logic [63:0] P2 = 64'h0000_0042_DEAD_0042;
  localparam logic [63:0] P3 = 64'h0000_0043_DEAD_0043;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  std_axi_req_t req;
  std_axi_rsp_t rsp;
  logic         busy;
  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         rq[$];
  exp_t         bq[$];
  exp_t         mon_e;
  logic [63:0]  wd [4];
  logic [7:0]   ws [4];
  logic [63:0]  re [4];

  always #5 clk = ~clk;

  std_axi_mem_responder #(.NumWords(1024)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .axi_req_i (req),
    .axi_rsp_o (rsp),
    .busy_o    (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp.r_valid && req.r_ready) begin
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL r_unexpected: got beat %h, expected no beat", rsp.r_data);
      end else begin
        mon_e = rq.pop_front();
        check("r_data", rsp.r_data, mon_e.data);
        check("r_id", 64'(rsp.r_id), 64'(mon_e.id));
        check("r_resp", 64'(rsp.r_resp), 64'(mon_e.resp));
        check("r_last", 64'(rsp.r_last), 64'(mon_e.last));
      end
    end
    if (!rst && rsp.b_valid && req.b_ready) begin
      if (bq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected: got b_id %0d, expected no response", rsp.b_id);
      end else begin
        mon_e = bq.pop_front();
        check("b_id", 64'(rsp.b_id), 64'(mon_e.id));
        check("b_resp", 64'(rsp.b_resp), 64'(mon_e.resp));
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0: return rsp.ar_ready;
      1: return rsp.aw_ready;
      2: return rsp.w_ready;
      default: return rsp.r_valid;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input string name, input int which);
    int n;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (sig(which)) break;
    end
    if (n == 30) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got 0 after 30 cycles, expected 1", name);
    end
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 60 && (rq.size() != 0 || bq.size() != 0); n++) @(posedge clk);
    #1;
    if (rq.size() != 0 || bq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d R and %0d B outstanding, expected 0", rq.size(), bq.size());
      rq.delete(); bq.delete();
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp, input logic last);
    exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    rq.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    exp_t e;
    e.id = id; e.data = '0; e.resp = resp; e.last = 1'b1;
    bq.push_back(e);
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    req.ar_valid = 1'b1; req.ar_id = id; req.ar_addr = addr;
    req.ar_len = len; req.ar_size = 3'd3; req.ar_burst = burst;
    wait_for("ar_hs", 0);
    tick();
    req.ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    req.aw_valid = 1'b1; req.aw_id = id; req.aw_addr = addr;
    req.aw_len = len; req.aw_size = 3'd3; req.aw_burst = burst;
    wait_for("aw_hs", 1);
    tick();
    req.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    req.w_valid = 1'b1; req.w_data = d; req.w_strb = strb; req.w_last = last;
    wait_for("w_hs", 2);
    tick();
    req.w_valid = 1'b0;
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len);
    push_b(id, RESP_OKAY);
    send_aw(id, addr, 8'(len), BURST_INCR);
    for (int i = 0; i <= len; i++) send_w(wd[i], ws[i], i == len);
    @(negedge clk);
    check("b_latency", 64'(rsp.b_valid), 64'd1);
    drain();
  endtask

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [1:0] resp);
    for (int i = 0; i <= len; i++) push_r(id, re[i], resp, i == len);
    send_ar(id, addr, 8'(len), burst);
    @(negedge clk);
    check("r_latency_c1", 64'(rsp.r_valid), 64'd0);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      check("r_back_to_back", 64'(rsp.r_valid), 64'd1);
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    req.r_ready = 1'b1;
    req.b_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
    check("rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
    check("rst_w_ready", 64'(rsp.w_ready), 64'd0);
    check("rst_b_valid", 64'(rsp.b_valid), 64'd0);
    check("rst_r_valid", 64'(rsp.r_valid), 64'd0);
    check("rst_r_last", 64'(rsp.r_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_r_data", rsp.r_data, 64'd0);
    tick();
    rst = 1'b0;

    // preload words 0x40..0x43
    wd[0] = P0; wd[1] = P1; wd[2] = P2; wd[3] = P3;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    wr_burst(4'd1, 32'h200, 3);

    // refill read
    re[0] = P0; re[1] = P1; re[2] = P2; re[3] = P3;
    rd_burst(4'd5, 32'h200, 3, BURST_INCR, RESP_OKAY);

    // writeback with partial strobe
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wr_burst(4'd2, 32'h100, 1);
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA; ws[0] = 8'hFF;
    wd[1] = 64'hBBBB_BBBB_BBBB_BBBB; ws[1] = 8'h0F;
    wr_burst(4'd2, 32'h100, 1);
    re[0] = 64'hAAAA_AAAA_AAAA_AAAA; re[1] = 64'h2222_2222_BBBB_BBBB;
    rd_burst(4'd4, 32'h100, 1, BURST_INCR, RESP_OKAY);

    // wrapping refill
    re[0] = P3; re[1] = P0; re[2] = P1; re[3] = P2;
    rd_burst(4'd3, 32'h218, 3, BURST_WRAP, RESP_OKAY);

    // r_ready backpressure mid-burst
    push_r(4'd6, P0, RESP_OKAY, 1'b0); push_r(4'd6, P1, RESP_OKAY, 1'b0);
    push_r(4'd6, P2, RESP_OKAY, 1'b0); push_r(4'd6, P3, RESP_OKAY, 1'b1);
    send_ar(4'd6, 32'h200, 8'd3, BURST_INCR);
    wait_for("bp_first_beat", 3);
    tick();
    req.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_r_valid_hold", 64'(rsp.r_valid), 64'd1);
      check("bp_r_data_hold", rsp.r_data, P1);
    end
    tick();
    req.r_ready = 1'b1;
    drain();

    // arbitration after a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_r(4'd7, P1, RESP_OKAY, 1'b1);
    push_b(4'd8, RESP_OKAY);
    push_r(4'd7, P1, RESP_OKAY, 1'b1);
    req.ar_valid = 1'b1; req.ar_id = 4'd7; req.ar_addr = 32'h208;
    req.ar_len = 8'd0; req.ar_size = 3'd3; req.ar_burst = BURST_INCR;
    req.aw_valid = 1'b1; req.aw_id = 4'd8; req.aw_addr = 32'h300;
    req.aw_len = 8'd0; req.aw_size = 3'd3; req.aw_burst = BURST_INCR;
    @(negedge clk);
    check("arb1_ar_ready", 64'(rsp.ar_ready), 64'd1);
    check("arb1_aw_ready", 64'(rsp.aw_ready), 64'd0);
    tick();
    wait_for("arb2_aw_ready", 1);
    check("arb2_ar_ready", 64'(rsp.ar_ready), 64'd0);
    tick();
    req.aw_valid = 1'b0;
    send_w(64'h3333_3333_3333_3333, 8'hFF, 1'b1);
    wait_for("arb3_ar_ready", 0);
    tick();
    req.ar_valid = 1'b0;
    drain();

    // reset during WR_DATA
    send_aw(4'd9, 32'h300, 8'd3, BURST_INCR);
    send_w(64'h4444_4444_4444_4444, 8'hFF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_b_valid", 64'(rsp.b_valid), 64'd0);
    check("mid_rst_w_ready", 64'(rsp.w_ready), 64'd0);
    check("mid_rst_ar_ready", 64'(rsp.ar_ready), 64'd0);
    check("mid_rst_aw_ready", 64'(rsp.aw_ready), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_b", 64'(rsp.b_valid), 64'd0);
    end
    tick();
    re[0] = 64'h4444_4444_4444_4444;
    rd_burst(4'd10, 32'h300, 0, BURST_INCR, RESP_OKAY);

`ifdef CVA6_AXI_MEM_RESP_ERR_EN
    re[0] = 64'd0;
    rd_burst(4'd11, 32'h2000, 0, BURST_INCR, RESP_SLVERR);
`endif

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
